// File: rtl/mdu_pkg.sv
// Shared definitions for the E-stage multiply/divide unit.
//   - mdu_op_e    : E_sel_MDU operation encodings (8..14 decode as none)
//   - *_LAT_DEF   : default busy latencies for multiply and divide
//   - mdu_state_e : scheduler FSM states
//   - is_md_op / is_div_op : operation class helpers
package mdu_pkg;

  typedef enum logic [3:0] {
    MDU_MULT  = 4'd0,
    MDU_MULTU = 4'd1,
    MDU_DIV   = 4'd2,
    MDU_DIVU  = 4'd3,
    MDU_MFHI  = 4'd4,
    MDU_MFLO  = 4'd5,
    MDU_MTHI  = 4'd6,
    MDU_MTLO  = 4'd7,
    MDU_NONE  = 4'd15
  } mdu_op_e;

  localparam int unsigned MULT_LAT_DEF = 5;
  localparam int unsigned DIV_LAT_DEF  = 10;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } mdu_state_e;

  // mult/multu/div/divu: the multi-cycle operations
  function automatic logic is_md_op(input logic [3:0] op);
    return (op == MDU_MULT) || (op == MDU_MULTU) ||
           (op == MDU_DIV)  || (op == MDU_DIVU);
  endfunction

  function automatic logic is_div_op(input logic [3:0] op);
    return (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

endpackage

// File: rtl/mdu_arith.sv
// Combinational arithmetic for the MDU.
// Produces the 64-bit {HI, LO} image an md operation will commit.
//   op     in  4   E-stage MDU operation
//   rs     in  32  rs operand (multiplicand / dividend)
//   rt     in  32  rt operand (multiplier / divisor)
//   hi     in  32  current committed HI
//   lo     in  32  current committed LO
//   result out 64  {HI, LO} result; divide by zero returns {hi, lo}
module mdu_arith
  import mdu_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [31:0] rs,
  input  logic [31:0] rt,
  input  logic [31:0] hi,
  input  logic [31:0] lo,
  output logic [63:0] result
);

  logic signed [63:0] rs_sx;
  logic signed [63:0] rt_sx;
  logic signed [63:0] prod_s;
  logic        [63:0] prod_u;
  logic signed [31:0] rs_s;
  logic signed [31:0] rt_s;
  logic signed [31:0] quo_s;
  logic signed [31:0] rem_s;
  logic        [31:0] quo_u;
  logic        [31:0] rem_u;
  logic               div_zero;

  assign rs_sx  = {{32{rs[31]}}, rs};
  assign rt_sx  = {{32{rt[31]}}, rt};
  assign prod_s = rs_sx * rt_sx;
  assign prod_u = {32'b0, rs} * {32'b0, rt};

  assign rs_s   = rs;
  assign rt_s   = rt;
  // Signed / and % truncate toward zero; remainder takes the dividend's sign.
  assign quo_s  = rs_s / rt_s;
  assign rem_s  = rs_s % rt_s;
  assign quo_u  = rs / rt;
  assign rem_u  = rs % rt;

  assign div_zero = (rt == '0);

  always_comb begin
    result = '0;
    case (op)
      MDU_MULT:  result = prod_s;
      MDU_MULTU: result = prod_u;
      MDU_DIV:   result = div_zero ? {hi, lo} : {rem_s, quo_s};
      MDU_DIVU:  result = div_zero ? {hi, lo} : {rem_u, quo_u};
      default:   result = '0;
    endcase
  end

endmodule

// File: rtl/mdu_sched.sv
// E-stage multiply/divide scheduler and HI/LO holder.
// Launches mult/multu/div/divu as multi-cycle operations, commits the result
// into HI/LO when the latency expires, serves mfhi/mflo/mthi/mtlo and stalls
// D-stage MDU instructions while an operation is starting or in flight.
// Optional feature: define MDU_DIV0_FAST_EN to make divide-by-zero complete
// immediately (start pulses, FSM stays IDLE, HI/LO unchanged).
//   MULT_LAT     param  busy cycles for mult/multu
//   DIV_LAT      param  busy cycles for div/divu
//   clk          in  1   clock, rising edge
//   reset        in  1   synchronous active-low reset
//   E_sel_MDU    in  4   E-stage MDU operation
//   E_rs, E_rt   in  32  forwarded operands
//   D_instr_mdu  in  1   D-stage instruction is an MDU instruction
//   req          in  1   flush; suppresses this cycle's E-stage side effects
//   start        out 1   md operation accepted this cycle
//   busy         out 1   operation in flight (registered)
//   stall_mdu    out 1   stall request toward D
//   E_MDUout     out 32  HI for mfhi, LO for mflo, else 0
//   HI, LO       out 32  committed HI/LO
module mdu_sched
  import mdu_pkg::*;
#(
  parameter int unsigned MULT_LAT = MULT_LAT_DEF,
  parameter int unsigned DIV_LAT  = DIV_LAT_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  E_sel_MDU,
  input  logic [31:0] E_rs,
  input  logic [31:0] E_rt,
  input  logic        D_instr_mdu,
  input  logic        req,
  output logic        start,
  output logic        busy,
  output logic        stall_mdu,
  output logic [31:0] E_MDUout,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int unsigned LAT_MAX = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
  localparam int unsigned CNT_W   = (LAT_MAX > 1) ? $clog2(LAT_MAX) : 1;
  localparam logic [CNT_W-1:0] MULT_CNT = CNT_W'(MULT_LAT - 1);
  localparam logic [CNT_W-1:0] DIV_CNT  = CNT_W'(DIV_LAT - 1);

  mdu_state_e       state;
  logic [CNT_W-1:0] count;
  logic [31:0]      shi;
  logic [31:0]      slo;
  logic [63:0]      arith_res;
  logic             is_div;
  logic             div0_skip;
  logic             mt_hi;
  logic             mt_lo;

  mdu_arith u_arith (
    .op     (E_sel_MDU),
    .rs     (E_rs),
    .rt     (E_rt),
    .hi     (HI),
    .lo     (LO),
    .result (arith_res)
  );

  assign is_div    = is_div_op(E_sel_MDU);
  assign start     = (state == IDLE) && is_md_op(E_sel_MDU) && !req;
  assign stall_mdu = D_instr_mdu && (start || busy);
  assign mt_hi     = (E_sel_MDU == MDU_MTHI) && !req;
  assign mt_lo     = (E_sel_MDU == MDU_MTLO) && !req;

`ifdef MDU_DIV0_FAST_EN
  assign div0_skip = is_div && (E_rt == '0);
`else
  assign div0_skip = 1'b0;
`endif

  always_comb begin
    E_MDUout = '0;
    case (E_sel_MDU)
      MDU_MFHI: E_MDUout = HI;
      MDU_MFLO: E_MDUout = LO;
      default:  E_MDUout = '0;
    endcase
  end

  // mthi/mtlo writes are issued before the FSM so that a commit on the same
  // edge overrides them.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      busy  <= 1'b0;
      count <= '0;
      shi   <= '0;
      slo   <= '0;
      HI    <= '0;
      LO    <= '0;
    end else begin
      if (mt_hi) HI <= E_rs;
      if (mt_lo) LO <= E_rs;
      case (state)
        IDLE: begin
          if (start && !div0_skip) begin
            shi   <= arith_res[63:32];
            slo   <= arith_res[31:0];
            count <= is_div ? DIV_CNT : MULT_CNT;
            state <= BUSY;
            busy  <= 1'b1;
          end
        end
        BUSY: begin
          if (count == '0) begin
            HI    <= shi;
            LO    <= slo;
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            count <= count - 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_sched.sv
module tb_mdu_sched;

  localparam int unsigned MLAT = 5;
  localparam int unsigned DLAT = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  E_sel_MDU;
  logic [31:0] E_rs;
  logic [31:0] E_rt;
  logic        D_instr_mdu;
  logic        req;
  logic        start;
  logic        busy;
  logic        stall_mdu;
  logic [31:0] E_MDUout;
  logic [31:0] HI;
  logic [31:0] LO;

  mdu_sched #(.MULT_LAT(MLAT), .DIV_LAT(DLAT)) dut (
    .clk         (clk),
    .reset       (reset),
    .E_sel_MDU   (E_sel_MDU),
    .E_rs        (E_rs),
    .E_rt        (E_rt),
    .D_instr_mdu (D_instr_mdu),
    .req         (req),
    .start       (start),
    .busy        (busy),
    .stall_mdu   (stall_mdu),
    .E_MDUout    (E_MDUout),
    .HI          (HI),
    .LO          (LO)
  );

  always #5 clk = ~clk;

  int unsigned total = 0;
  int unsigned bad   = 0;

  // Reference model: committed HI/LO, the pending result and how many busy
  // cycles remain before it lands.
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;
  logic [31:0] p_hi = '0;
  logic [31:0] p_lo = '0;
  int unsigned m_left = 0;

  int unsigned stall_seen;
  int unsigned busy_seen;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Architectural result of an md operation from its definition.
  task automatic ref_calc(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] h, output logic [31:0] l);
    longint          ps;
    longint unsigned pu;
    logic [31:0]     ua, ub, q, r;
    h = m_hi;
    l = m_lo;
    case (op)
      4'd0: begin
        ps = longint'($signed(a)) * longint'($signed(b));
        h = ps[63:32]; l = ps[31:0];
      end
      4'd1: begin
        pu = {32'b0, a} * {32'b0, b};
        h = pu[63:32]; l = pu[31:0];
      end
      4'd2: if (b != 0) begin
        ua = a[31] ? -a : a;
        ub = b[31] ? -b : b;
        q = ua / ub;
        r = ua % ub;
        if (a[31] != b[31]) q = -q;
        if (a[31]) r = -r;
        h = r; l = q;
      end
      4'd3: if (b != 0) begin
        h = a % b; l = a / b;
      end
      default: ;
    endcase
  endtask

  // One clock cycle: drive inputs, check outputs against the model,
  // advance the model across the rising edge.
  task automatic step(input logic [3:0] op, input logic [31:0] rs, input logic [31:0] rt,
                      input logic d, input logic rq, input logic rst);
    logic        e_busy, e_start, e_stall;
    logic [31:0] e_out, h, l;
    E_sel_MDU = op; E_rs = rs; E_rt = rt; D_instr_mdu = d; req = rq; reset = rst;
    #1;
    e_busy  = (m_left > 0);
    e_start = !e_busy && (op <= 4'd3) && !rq;
    e_stall = d && (e_start || e_busy);
    e_out   = (op == 4'd4) ? m_hi : (op == 4'd5) ? m_lo : 32'd0;
    check("busy", busy, e_busy);
    check("start", start, e_start);
    check("stall_mdu", stall_mdu, e_stall);
    check("E_MDUout", E_MDUout, e_out);
    check("HI", HI, m_hi);
    check("LO", LO, m_lo);
    if (stall_mdu) stall_seen++;
    if (busy) busy_seen++;
    @(posedge clk);
    if (!rst) begin
      m_hi = '0; m_lo = '0; m_left = 0;
    end else begin
      if (!rq && op == 4'd6) m_hi = rs;
      if (!rq && op == 4'd7) m_lo = rs;
      if (m_left > 0) begin
        m_left--;
        if (m_left == 0) begin m_hi = p_hi; m_lo = p_lo; end
      end else if (e_start) begin
        ref_calc(op, rs, rt, h, l);
        p_hi = h; p_lo = l;
        m_left = (op >= 4'd2) ? DLAT : MLAT;
`ifdef MDU_DIV0_FAST_EN
        if (op >= 4'd2 && rt == 0) m_left = 0;
`endif
      end
    end
    @(negedge clk);
  endtask

  task automatic idle(input int unsigned n, input logic d);
    for (int unsigned i = 0; i < n; i++) step(4'd15, $urandom, $urandom, d, 1'b0, 1'b1);
  endtask

  initial begin
    logic [3:0]  op;
    logic [31:0] rs, rt;
    int unsigned r;
    @(negedge clk);
    for (int i = 0; i < 3; i++) step(4'd15, '0, '0, 1'b0, 1'b0, 1'b0);

    // mult -3 * 7
    step(4'd0, -32'sd3, 32'd7, 1'b0, 1'b0, 1'b1);
    idle(MLAT, 1'b0);
    check("mult_hi", HI, 32'hFFFF_FFFF);
    check("mult_lo", LO, 32'hFFFF_FFEB);

    // divu 100 / 7 with D-stage MDU instruction waiting
    stall_seen = 0;
    step(4'd3, 32'd100, 32'd7, 1'b1, 1'b0, 1'b1);
    idle(DLAT + 1, 1'b1);
    check("divu_stall_cycles", stall_seen, DLAT + 1);
    check("divu_lo", LO, 32'd14);
    check("divu_hi", HI, 32'd2);

    // div -7 / 2
    step(4'd2, -32'sd7, 32'd2, 1'b0, 1'b0, 1'b1);
    idle(DLAT, 1'b0);
    check("div_lo", LO, 32'hFFFF_FFFD);
    check("div_hi", HI, 32'hFFFF_FFFF);

    // divide by zero leaves HI/LO alone
    step(4'd6, 32'h11, '0, 1'b0, 1'b0, 1'b1);
    step(4'd7, 32'h22, '0, 1'b0, 1'b0, 1'b1);
    busy_seen = 0;
    step(4'd2, 32'd5, 32'd0, 1'b0, 1'b0, 1'b1);
    idle(DLAT + 1, 1'b0);
`ifdef MDU_DIV0_FAST_EN
    check("div0_busy_cycles", busy_seen, 0);
`else
    check("div0_busy_cycles", busy_seen, DLAT);
`endif
    check("div0_hi", HI, 32'h11);
    check("div0_lo", LO, 32'h22);

    // flush suppresses md start and mthi
    step(4'd0, 32'd9, 32'd9, 1'b0, 1'b1, 1'b1);
    step(4'd6, 32'h5, '0, 1'b0, 1'b1, 1'b1);
    check("req_busy", busy, 1'b0);
    check("req_hi", HI, 32'h11);
    check("req_lo", LO, 32'h22);

    // reset mid-divide discards the result
    step(4'd2, 32'd1000, 32'd3, 1'b0, 1'b0, 1'b1);
    step(4'd15, '0, '0, 1'b0, 1'b0, 1'b1);
    step(4'd15, '0, '0, 1'b0, 1'b0, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_hi", HI, 32'd0);
    check("rst_lo", LO, 32'd0);
    step(4'd7, 32'hA, '0, 1'b0, 1'b0, 1'b1);
    #1;
    E_sel_MDU = 4'd5;
    #1;
    check("mflo_after_mtlo", E_MDUout, 32'hA);
    step(4'd5, '0, '0, 1'b0, 1'b0, 1'b1);

    // randomized traffic
    for (int i = 0; i < 800; i++) begin
      r = $urandom_range(0, 19);
      if (r < 8)       op = 4'(r);
      else if (r < 12) op = 4'($urandom_range(8, 15));
      else             op = 4'd15;
      rs = $urandom;
      rt = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 3) == 0) rt = rt & 32'hFF;
      if (op == 4'd2 && rs == 32'h8000_0000 && rt == 32'hFFFF_FFFF) rt = 32'd1;
      step(op, rs, rt, 1'($urandom_range(0, 1)), ($urandom_range(0, 9) == 0), 1'b1);
    end
    idle(DLAT + 1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
